ram_burst_scheduler: RTL and testbench

- Parametrised successor to the fixed 8-FIFO memory arbitration path.
- Schedules fixed-length bursts between NUM_CH channel pairs and the cell RAM:
  - FIFO->RAM ("write") bursts, fed by USB EP2 / ADC tracking FIFOs.
  - RAM->FIFO ("read") bursts, feeding DAC / EP6 tracking FIFOs.
- Each channel owns a circular region of RAM and keeps its own write pointer, read pointer and occupancy.
- Issues one burst command at a time to the RAM sequencer, using round-robin grant across 2*NUM_CH requesters.

---
 rtl/ram_burst_scheduler_if.sv | 30 +++
 rtl/ram_burst_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_ram_burst_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_scheduler_if
// Purpose  : Burst command / completion handshake between the scheduler and
//            the RAM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_burst_scheduler_if #(
    parameter int ADDR_W = 23,
    parameter int CNT_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [2:0]        cmd_chan;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_len;
    logic              burst_done;

    modport master (
        output cmd_valid, cmd_dir, cmd_chan, cmd_addr, cmd_len,
        input  cmd_ready, burst_done
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_chan, cmd_addr, cmd_len,
        output cmd_ready, burst_done
    );
endinterface
`default_nettype wire

// File: rtl/ram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_scheduler
// Purpose  : Round-robin scheduler of fixed-length FIFO<->RAM bursts over
//            NUM_CH circular RAM regions, one command in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 11,
    parameter int BURST_LEN   = 32,
    parameter int REGION_LOG2 = 10,
    parameter int ADDR_W      = 23
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    input  wire logic [NUM_CH-1:0]                 chan_enable,
    input  wire logic [NUM_CH-1:0]                 chan_flush,
    input  wire logic [NUM_CH*CNT_W-1:0]           write_fifo_levels,
    input  wire logic [NUM_CH*CNT_W-1:0]           read_fifo_spaces,
    ram_burst_scheduler_if.master                  cmd_bus,
    output logic [NUM_CH*(REGION_LOG2+1)-1:0]      ram_occupancy,
    output logic                                   busy
);

    localparam int c_num_req = 2 * NUM_CH;
    localparam int c_req_w   = $clog2(c_num_req);
    localparam int c_occ_w   = REGION_LOG2 + 1;

    localparam logic [c_occ_w-1:0]     c_burst_occ  = c_occ_w'(BURST_LEN);
    localparam logic [REGION_LOG2-1:0] c_burst_ptr  = REGION_LOG2'(BURST_LEN);
    localparam logic [c_occ_w-1:0]     c_occ_wr_max = c_occ_w'((1 << REGION_LOG2) - BURST_LEN);
    localparam logic [CNT_W-1:0]       c_burst_cnt  = CNT_W'(BURST_LEN);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_issue  = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_update = 2'd3;

    logic [1:0]              r_state;
    logic [c_req_w-1:0]      r_rr_ptr;
    logic [c_req_w-1:0]      r_grant;
    logic                    r_flush_pend;
    logic                    r_cmd_valid;
    logic                    r_cmd_dir;
    logic [2:0]              r_cmd_chan;
    logic [ADDR_W-1:0]       r_cmd_addr;
    logic [CNT_W-1:0]        r_cmd_len;
    logic                    r_busy;
    logic [REGION_LOG2-1:0]  r_wptr [NUM_CH];
    logic [REGION_LOG2-1:0]  r_rptr [NUM_CH];
    logic [c_occ_w-1:0]      r_occ  [NUM_CH];

    logic [NUM_CH-1:0]       w_wr_elig;
    logic [NUM_CH-1:0]       w_rd_elig;
    logic [c_num_req-1:0]    w_req;
    logic                    w_found;
    logic [c_req_w-1:0]      w_sel;
    logic                    w_sel_dir;
    logic [2:0]              w_sel_chan;
    logic [REGION_LOG2-1:0]  w_sel_ptr;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic                    w_active_flush;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_wr_elig[g] = chan_enable[g] & ~chan_flush[g]
                            & (write_fifo_levels[g*CNT_W +: CNT_W] >= c_burst_cnt)
                            & (r_occ[g] <= c_occ_wr_max);
        assign w_rd_elig[g] = chan_enable[g] & ~chan_flush[g]
                            & (r_occ[g] >= c_burst_occ)
                            & (read_fifo_spaces[g*CNT_W +: CNT_W] >= c_burst_cnt);
        assign ram_occupancy[g*c_occ_w +: c_occ_w] = r_occ[g];
    end

    assign w_req = {w_rd_elig, w_wr_elig};

    // First eligible requester at or after rr_ptr, modulo 2*NUM_CH.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < c_num_req; k++) begin
            if (!w_found && w_req[(int'(r_rr_ptr) + k) % c_num_req]) begin
                w_found = 1'b1;
                w_sel   = c_req_w'((int'(r_rr_ptr) + k) % c_num_req);
            end
        end
    end

    always_comb begin
        w_sel_dir  = (w_sel >= c_req_w'(NUM_CH));
        w_sel_chan = w_sel_dir ? 3'(w_sel - c_req_w'(NUM_CH)) : 3'(w_sel);
        w_sel_ptr  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel_chan == 3'(c)) begin
                w_sel_ptr = w_sel_dir ? r_rptr[c] : r_wptr[c];
            end
        end
        w_sel_addr = ADDR_W'({w_sel_chan, w_sel_ptr});
    end

    always_comb begin
        w_active_flush = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_cmd_chan == 3'(c) && chan_flush[c]) begin
                w_active_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_flush_pend <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_dir    <= 1'b0;
            r_cmd_chan   <= '0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_busy       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_occ[c]  <= '0;
            end
        end else begin
            // The channel owning the in-flight burst is cleared in UPDATE instead.
            for (int c = 0; c < NUM_CH; c++) begin
                if (chan_flush[c] && !(r_state != c_st_idle && r_cmd_chan == 3'(c))) begin
                    r_wptr[c] <= '0;
                    r_rptr[c] <= '0;
                    r_occ[c]  <= '0;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant      <= w_sel;
                        r_cmd_dir    <= w_sel_dir;
                        r_cmd_chan   <= w_sel_chan;
                        r_cmd_addr   <= w_sel_addr;
                        r_cmd_len    <= c_burst_cnt;
                        r_cmd_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_flush_pend <= 1'b0;
                        r_state      <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_active_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (cmd_bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (w_active_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (cmd_bus.burst_done) begin
                        r_state <= c_st_update;
                    end
                end
                c_st_update: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (r_cmd_chan == 3'(c)) begin
                            if (r_flush_pend || chan_flush[c]) begin
                                r_wptr[c] <= '0;
                                r_rptr[c] <= '0;
                                r_occ[c]  <= '0;
                            end else if (!r_cmd_dir) begin
                                r_wptr[c] <= r_wptr[c] + c_burst_ptr;
                                r_occ[c]  <= r_occ[c] + c_burst_occ;
                            end else begin
                                r_rptr[c] <= r_rptr[c] + c_burst_ptr;
                                r_occ[c]  <= r_occ[c] - c_burst_occ;
                            end
                        end
                    end
                    r_rr_ptr     <= (r_grant == c_req_w'(c_num_req - 1)) ? '0 : r_grant + 1'b1;
                    r_flush_pend <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_bus.cmd_valid = r_cmd_valid;
    assign cmd_bus.cmd_dir   = r_cmd_dir;
    assign cmd_bus.cmd_chan  = r_cmd_chan;
    assign cmd_bus.cmd_addr  = r_cmd_addr;
    assign cmd_bus.cmd_len   = r_cmd_len;
    assign busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_scheduler
// Purpose  : Directed scoreboard bench for ram_burst_scheduler (NUM_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 11;
    localparam int OCC_W  = 11;

    typedef struct packed {
        logic        dir;
        logic [2:0]  chan;
        logic [22:0] addr;
    } cmd_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         chan_enable;
    logic [NUM_CH-1:0]         chan_flush;
    logic [NUM_CH*CNT_W-1:0]   levels;
    logic [NUM_CH*CNT_W-1:0]   spaces;
    logic [NUM_CH*OCC_W-1:0]   ram_occupancy;
    logic                      busy;

    cmd_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ram_burst_scheduler_if #(.ADDR_W(23), .CNT_W(CNT_W)) bus ();

    ram_burst_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_LEN(32), .REGION_LOG2(10), .ADDR_W(23)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .chan_enable       (chan_enable),
        .chan_flush        (chan_flush),
        .write_fifo_levels (levels),
        .read_fifo_spaces  (spaces),
        .cmd_bus           (bus),
        .ram_occupancy     (ram_occupancy),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OCC_W-1:0] occ(input int ch);
        return ram_occupancy[ch*OCC_W +: OCC_W];
    endfunction

    task automatic set_level(input int ch, input int val);
        levels[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic set_space(input int ch, input int val);
        spaces[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic push(input logic dir, input logic [2:0] ch, input logic [22:0] addr);
        cmd_t e;
        e.dir  = dir;
        e.chan = ch;
        e.addr = addr;
        sb.push_back(e);
    endtask

    // Wait for a command, compare it against the scoreboard head, then accept it.
    task automatic accept(input string tag);
        cmd_t e;
        int   n;
        n = 0;
        while (bus.cmd_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.cmd_valid, 1'b1);
        if (bus.cmd_valid === 1'b1) begin
            check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
            e = '0;
            if (sb.size() > 0) e = sb.pop_front();
            check({tag, "_dir"},  bus.cmd_dir,  e.dir);
            check({tag, "_chan"}, bus.cmd_chan, e.chan);
            check({tag, "_addr"}, bus.cmd_addr, e.addr);
            check({tag, "_len"},  bus.cmd_len,  11'd32);
            bus.cmd_ready = 1'b1;
            @(negedge clk);
            bus.cmd_ready = 1'b0;
            check({tag, "_valid_drop"}, bus.cmd_valid, 1'b0);
        end
    endtask

    task automatic finish_burst(input string tag);
        int n;
        repeat (2) @(negedge clk);
        bus.burst_done = 1'b1;
        @(negedge clk);
        bus.burst_done = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        chan_enable    = '1;
        chan_flush     = '0;
        levels         = '0;
        spaces         = '0;
        bus.cmd_ready  = 1'b0;
        bus.burst_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.cmd_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_occ",   ram_occupancy, '0);
        check("rst_addr",  bus.cmd_addr, '0);
        check("rst_len",   bus.cmd_len, '0);
        reset = 1'b0;

        // Level just below a burst is not eligible.
        set_level(1, 31);
        repeat (3) @(negedge clk);
        check("lvl31_no_cmd", bus.cmd_valid, 1'b0);

        // Single ch1 write; command appears one cycle after eligibility.
        set_level(1, 40);
        push(1'b0, 3'd1, 23'h400);
        @(negedge clk);
        check("w1_latency", bus.cmd_valid, 1'b1);
        accept("w1");
        set_level(1, 0);
        finish_burst("w1");
        check("w1_occ1", occ(1), 11'd32);

        // Round robin: W0 first, then W2, R1, W0, W2 with all three eligible.
        set_level(0, 64);
        push(1'b0, 3'd0, 23'h000);
        accept("rr_w0a");
        set_level(2, 64);
        set_space(1, 64);
        finish_burst("rr_w0a");
        push(1'b0, 3'd2, 23'h800);
        push(1'b1, 3'd1, 23'h400);
        push(1'b0, 3'd0, 23'h020);
        push(1'b0, 3'd2, 23'h820);
        accept("rr_w2a");
        finish_burst("rr_w2a");
        accept("rr_r1");
        finish_burst("rr_r1");
        check("rr_occ1_zero", occ(1), 11'd0);
        accept("rr_w0b");
        finish_burst("rr_w0b");
        accept("rr_w2b");
        set_level(0, 0);
        set_level(2, 0);
        set_space(1, 0);
        finish_burst("rr_w2b");
        check("rr_occ0", occ(0), 11'd64);
        check("rr_occ2", occ(2), 11'd64);

        // Fill ch3's whole region, confirm refusal when full, then drain it.
        set_level(3, 64);
        for (int i = 0; i < 32; i++) begin
            push(1'b0, 3'd3, 23'(32'hC00 + 32 * i));
            accept("fill_w3");
            finish_burst("fill_w3");
        end
        check("full_occ3", occ(3), 11'd1024);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_refused", bus.cmd_valid, 1'b0);
        end
        set_level(3, 0);
        set_space(3, 64);
        for (int i = 0; i < 32; i++) begin
            push(1'b1, 3'd3, 23'(32'hC00 + 32 * i));
            accept("drain_r3");
            finish_burst("drain_r3");
        end
        check("drain_occ3", occ(3), 11'd0);
        set_space(3, 0);

        // Wrapped write pointer, stalled handshake and a spurious burst_done.
        set_level(3, 64);
        push(1'b0, 3'd3, 23'hC00);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", bus.cmd_valid, 1'b1);
            check("stall_addr",  bus.cmd_addr, 23'hC00);
            check("stall_chan",  bus.cmd_chan, 3'd3);
            bus.burst_done = (i == 3);
            @(negedge clk);
        end
        bus.burst_done = 1'b0;
        accept("stall_w3");
        set_level(3, 0);
        finish_burst("stall_w3");
        check("stall_occ3", occ(3), 11'd32);

        // Flush ch2 while its write is in flight; ch0 flushed while idle.
        set_level(2, 64);
        push(1'b0, 3'd2, 23'h840);
        accept("fl_w2");
        chan_flush = 4'b0100;
        finish_burst("fl_w2");
        check("fl_occ2", occ(2), 11'd0);
        chan_flush = 4'b0101;
        @(negedge clk);
        check("fl_occ0", occ(0), 11'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fl_no_grant", bus.cmd_valid, 1'b0);
        end
        chan_flush = 4'b0000;
        push(1'b0, 3'd2, 23'h800);
        push(1'b1, 3'd2, 23'h800);
        accept("fl_w2_after");
        set_level(2, 0);
        set_space(2, 64);
        finish_burst("fl_w2_after");
        accept("fl_r2_after");
        set_space(2, 0);
        finish_burst("fl_r2_after");
        check("fl_occ2_final", occ(2), 11'd0);

        // Reset during WAIT; rr_ptr left at 2 must be cleared to 0.
        set_level(1, 64);
        push(1'b0, 3'd1, 23'h420);
        accept("rs_w1");
        set_level(1, 0);
        set_level(2, 64);
        finish_burst("rs_w1");
        push(1'b0, 3'd2, 23'h820);
        accept("rs_w2");
        #2 reset = 1'b1;
        #1;
        check("rs_valid", bus.cmd_valid, 1'b0);
        check("rs_busy",  busy, 1'b0);
        check("rs_occ",   ram_occupancy, '0);
        check("rs_addr",  bus.cmd_addr, '0);
        check("rs_chan",  bus.cmd_chan, '0);
        check("rs_len",   bus.cmd_len, '0);
        @(negedge clk);
        reset = 1'b0;
        set_level(0, 64);
        push(1'b0, 3'd0, 23'h000);
        accept("rs_w0");
        set_level(0, 0);
        set_level(2, 0);
        finish_burst("rs_w0");
        check("rs_occ0", occ(0), 11'd32);
        check("rs_occ2", occ(2), 11'd0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
